// File: rtl/alu_issue.sv
// alu_issue: decodes an ALU operation, registers its operands and control code,
// drives them to an external combinational ALU for one cycle, then holds the
// registered result until downstream accepts it.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake for a new operation
//   aluop, funct          operation class and R-type function field
//   opa, opb              source operands
//   alu_in1, alu_in2      registered operands to the ALU
//   alu_ctrl              registered ALU operation code
//   alu_out, alu_zero     ALU combinational result and zero flag
//   res_valid / res_ready downstream handshake for the result
//   result, res_zero      registered ALU result and zero flag
//   illegal               registered: operation did not decode
//   branch_taken          (only with ALU_ISSUE_BRANCH_EN) zero flag of a branch op
//
// Optional feature macro: ALU_ISSUE_BRANCH_EN adds the branch_taken output.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  aluop,
    input  logic [5:0]  funct,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] result,
    output logic        res_zero,
    output logic        illegal
`ifdef ALU_ISSUE_BRANCH_EN
    ,
    output logic        branch_taken
`endif
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] in1_q, in2_q, result_q;
    logic [3:0]  ctrl_q;
    logic        pend_ill_q, illegal_q, zero_q;
    logic [3:0]  dec_ctrl;
    logic        dec_ill;
    logic        accept;

    // Operation decode
    always_comb begin
        dec_ctrl = 4'b1111;
        dec_ill  = 1'b1;
        case (aluop)
            2'b00: begin dec_ctrl = 4'b0010; dec_ill = 1'b0; end
            2'b01: begin dec_ctrl = 4'b0110; dec_ill = 1'b0; end
            2'b10: begin
                dec_ill = 1'b0;
                case (funct)
                    6'b100000: dec_ctrl = 4'b0010;
                    6'b100010: dec_ctrl = 4'b0110;
                    6'b100100: dec_ctrl = 4'b0000;
                    6'b100101: dec_ctrl = 4'b0001;
                    6'b100111: dec_ctrl = 4'b1100;
                    6'b101010: dec_ctrl = 4'b0111;
                    default: begin dec_ctrl = 4'b1111; dec_ill = 1'b1; end
                endcase
            end
            default: begin dec_ctrl = 4'b1111; dec_ill = 1'b1; end
        endcase
    end

    // Next state and handshake
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StExec;
            end
            StExec: state_d = StDone;
            StDone: begin
                in_ready = res_ready;
                if (res_ready) state_d = in_valid ? StExec : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand and control capture; the ALU only ever sees these registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in1_q      <= '0;
            in2_q      <= '0;
            ctrl_q     <= '0;
            pend_ill_q <= 1'b0;
        end else if (accept) begin
            in1_q      <= opa;
            in2_q      <= opb;
            ctrl_q     <= dec_ctrl;
            pend_ill_q <= dec_ill;
        end
    end

    // Result capture at the end of the EXEC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (state_q == StExec) begin
            result_q  <= alu_out;
            zero_q    <= alu_zero;
            illegal_q <= pend_ill_q;
        end
    end

`ifdef ALU_ISSUE_BRANCH_EN
    logic is_br_q, branch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_br_q  <= 1'b0;
            branch_q <= 1'b0;
        end else begin
            if (accept) is_br_q <= (aluop == 2'b01);
            if (state_q == StExec) branch_q <= is_br_q & alu_zero;
        end
    end

    assign branch_taken = branch_q;
`endif

    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;
    assign alu_ctrl  = ctrl_q;
    assign res_valid = (state_q == StDone);
    assign result    = result_q;
    assign res_zero  = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: directed scenarios plus randomized operations, checked
// against a reference model computed directly from the operation semantics.
module tb_alu_issue;

    logic        clk, rst, in_valid, in_ready, res_valid, res_ready;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] opa, opb, alu_in1, alu_in2, alu_out, result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero, res_zero, illegal;
`ifdef ALU_ISSUE_BRANCH_EN
    logic        branch_taken;
`endif

    int checks = 0;
    int failures = 0;

    alu_issue dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .funct     (funct),
        .opa       (opa),
        .opb       (opb),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .res_zero  (res_zero),
        .illegal   (illegal)
`ifdef ALU_ISSUE_BRANCH_EN
        ,
        .branch_taken (branch_taken)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model
    always_comb begin
        alu_out = 32'h0;
        case (alu_ctrl)
            4'b0010: alu_out = alu_in1 + alu_in2;
            4'b0110: alu_out = alu_in1 - alu_in2;
            4'b0000: alu_out = alu_in1 & alu_in2;
            4'b0001: alu_out = alu_in1 | alu_in2;
            4'b1100: alu_out = ~(alu_in1 | alu_in2);
            4'b0111: alu_out = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
            default: alu_out = 32'h0;
        endcase
        alu_zero = (alu_out == 32'h0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: what the operation means, independent of how it is sequenced
    task automatic ref_op(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, output logic [3:0] ctrl,
                          output logic [31:0] res, output logic ill);
        ill  = 1'b0;
        ctrl = 4'b1111;
        res  = 32'h0;
        if (op == 2'd0) begin ctrl = 4'b0010; res = a + b; end
        else if (op == 2'd1) begin ctrl = 4'b0110; res = a - b; end
        else if (op == 2'd2 && fn == 6'h20) begin ctrl = 4'b0010; res = a + b; end
        else if (op == 2'd2 && fn == 6'h22) begin ctrl = 4'b0110; res = a - b; end
        else if (op == 2'd2 && fn == 6'h24) begin ctrl = 4'b0000; res = a & b; end
        else if (op == 2'd2 && fn == 6'h25) begin ctrl = 4'b0001; res = a | b; end
        else if (op == 2'd2 && fn == 6'h27) begin ctrl = 4'b1100; res = ~(a | b); end
        else if (op == 2'd2 && fn == 6'h2a) begin
            ctrl = 4'b0111;
            res  = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        end
        else ill = 1'b1;
    endtask

    // Issue one operation from IDLE or DONE; leaves the DUT in DONE after `stall`
    // extra cycles with res_ready low. Junk in_valid traffic must be ignored.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input int stall);
        logic [3:0]  ectrl;
        logic [31:0] eres;
        logic        eill;
        ref_op(op, fn, a, b, ectrl, eres, eill);
        aluop = op; funct = fn; opa = a; opb = b;
        in_valid = 1'b1; res_ready = 1'b1;
        #1 chk("in_ready_accept", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        aluop = 2'($urandom); funct = 6'($urandom); opa = $urandom; opb = $urandom;
        res_ready = (stall == 0);
        chk("exec_res_valid", {31'b0, res_valid}, 32'd0);
        chk("exec_in_ready", {31'b0, in_ready}, 32'd0);
        chk("exec_ctrl", {28'b0, alu_ctrl}, {28'b0, ectrl});
        chk("exec_in1", alu_in1, a);
        chk("exec_in2", alu_in2, b);
        @(posedge clk); #1;
        chk("done_res_valid", {31'b0, res_valid}, 32'd1);
        chk("done_result", result, eres);
        chk("done_zero", {31'b0, res_zero}, {31'b0, eres == 32'h0});
        chk("done_illegal", {31'b0, illegal}, {31'b0, eill});
`ifdef ALU_ISSUE_BRANCH_EN
        chk("done_branch", {31'b0, branch_taken}, {31'b0, (op == 2'd1) && (eres == 32'h0)});
`endif
        for (int i = 0; i < stall; i++) begin
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
            opa = $urandom;
            chk("stall_res_valid", {31'b0, res_valid}, 32'd1);
            chk("stall_result", result, eres);
            chk("stall_illegal", {31'b0, illegal}, {31'b0, eill});
        end
    endtask

    task automatic drain();
        in_valid = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_res_valid", {31'b0, res_valid}, 32'd0);
        chk("drain_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
        aluop = '0; funct = '0; opa = '0; opb = '0;
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_ctrl", {28'b0, alu_ctrl}, 32'd0);
        chk("rst_in1", alu_in1, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Directed: ADD 5+7, branch equal, illegal funct, stall with hand-off
        issue(2'b10, 6'b100000, 32'd5, 32'd7, 0);
        drain();
        issue(2'b01, 6'b000000, 32'h1234, 32'h1234, 0);
        drain();
        issue(2'b10, 6'b000000, 32'd9, 32'd4, 0);
        drain();
        issue(2'b11, 6'b100000, 32'd1, 32'd2, 1);
        issue(2'b00, 6'b000000, 32'd100, 32'd23, 4);
        issue(2'b10, 6'b100010, 32'd3, 32'd10, 0);
        drain();

        // Back-to-back stream: SLT, NOR, AND at 2-cycle spacing
        issue(2'b10, 6'b101010, 32'd3, 32'd9, 0);
        issue(2'b10, 6'b100111, 32'd0, 32'd0, 0);
        issue(2'b10, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 0);
        drain();

        // Asynchronous reset in the middle of EXEC
        aluop = 2'b00; opa = 32'd50; opb = 32'd60; in_valid = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_ctrl", {28'b0, alu_ctrl}, 32'd0);
        chk("arst_in1", alu_in1, 32'd0);
        chk("arst_in2", alu_in2, 32'd0);
        chk("arst_illegal", {31'b0, illegal}, 32'd0);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("arst_no_result", {31'b0, res_valid}, 32'd0);
        end

        // Randomized operations, occasionally equal operands to exercise zero
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [5:0]  fn;
            logic [31:0] a, b;
            int sel;
            op  = 2'($urandom);
            sel = int'($urandom_range(0, 6));
            case (sel)
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h25;
                4: fn = 6'h27;
                5: fn = 6'h2a;
                default: fn = 6'($urandom);
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            issue(op, fn, a, b, int'($urandom_range(0, 2)));
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 in_valid  input  1  upstream presents an operation.
REQ-004 in_ready  output  1  block can accept an operation this cycle.
REQ-005 aluop  input  2  class: 00 load/store add, 01 branch subtract, 10 R-type via funct, 11 reserved.
REQ-006 funct  input  6  R-type function field, used only when aluop=10.
REQ-007 opa, opb  input  32 each  source operands.
REQ-008 alu_in1, alu_in2  output  32 each  operands driven to the ALU.
REQ-009 alu_ctrl  output  4  ALU operation code.
REQ-010 alu_out  input  32  ALU combinational result.
REQ-011 alu_zero  input  1  ALU zero flag.
REQ-012 res_valid  output  1  result and flags are valid.
REQ-013 res_ready  input  1  downstream accepts the result.
REQ-014 result  output  32  registered ALU result.
REQ-015 res_zero  output  1  registered zero flag.
REQ-016 illegal  output  1  registered: the operation decoded as illegal.

Function
REQ-017 Decode SHALL map: aluop 00->0010; 01->0110; 10 with funct 100000->0010, 100010->0110, 100100->0000, 100101->0001, 100111->1100, 101010->0111.
REQ-018 Any other aluop/funct combination SHALL decode to alu_ctrl=1111 with illegal=1 and SHALL still complete through the FSM.
REQ-019 FSM SHALL have states IDLE, EXEC and DONE.
REQ-020 IDLE: in_ready=1; on in_valid, capture opa, opb and the decoded ctrl into registers; next state EXEC.
REQ-021 EXEC: one cycle; alu_in1/alu_in2/alu_ctrl driven from registers; at cycle end, capture alu_out->result and alu_zero->res_zero; next state DONE.
REQ-022 DONE: res_valid=1; result, res_zero and illegal held stable until res_ready=1.
REQ-023 DONE with res_ready=1 and in_valid=0 SHALL return to IDLE.
REQ-024 DONE with res_ready=1 and in_valid=1 SHALL capture the new operation and go directly to EXEC; in_ready = IDLE | (DONE & res_ready).
REQ-025 Latency: operation accepted at edge N SHALL show res_valid=1 after edge N+2; sustained throughput one operation per 2 cycles.
REQ-026 in_valid while in EXEC, or in DONE without res_ready, SHALL be ignored (in_ready=0).
REQ-027 alu_in1, alu_in2 and alu_ctrl SHALL come only from registers, never combinationally from inputs.

Reset
REQ-028 rst=1 SHALL force IDLE immediately, regardless of clock, including mid-EXEC or mid-DONE; in-flight operation discarded.
REQ-029 Reset values: in_ready=1, res_valid=0, result=0, res_zero=0, illegal=0, alu_in1=0, alu_in2=0, alu_ctrl=0000.
REQ-030 First operation after rst deassertion SHALL be accepted on the first rising edge with in_valid=1.

Configuration
REQ-031 Macro ALU_ISSUE_BRANCH_EN SHALL, when defined, add output branch_taken (1 bit), registered with result, equal to res_zero when aluop was 01, else 0; reset value 0.
REQ-032 Without ALU_ISSUE_BRANCH_EN, port branch_taken and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 aluop=10, funct=100000, opa=5, opb=7 -> alu_ctrl=0010 in EXEC; res_valid after 2 edges, result=12, res_zero=0, illegal=0.
REQ-034 aluop=01, opa=opb=0x1234 -> alu_ctrl=0110, result=0, res_zero=1; with macro, branch_taken=1.
REQ-035 aluop=10, funct=000000 -> alu_ctrl=1111, result=0, res_zero=1, illegal=1.
REQ-036 res_ready held 0 for 4 cycles in DONE -> result stable, in_ready=0, new in_valid ignored; res_ready=1 with in_valid=1 -> next op enters EXEC same edge.
REQ-037 rst pulsed asynchronously mid-EXEC -> outputs at reset values before next edge; no res_valid for the discarded op.
REQ-038 Back-to-back stream (SLT 3<9, NOR 0,0, AND 0xF0F0,0xFF00) with res_ready=1 -> results 1, 0xFFFFFFFF, 0xF000 at 2-cycle spacing.
